// File: rtl/fetch_pkg.sv
// Shared constants, queue entry type and width helper for the fetch front-end.
package fetch_pkg;

    localparam int unsigned XLEN_DEF      = 32;
    localparam int unsigned DEPTH_DEF     = 4;
    localparam logic [63:0] RESET_VEC_DEF = 64'h0;
    localparam int unsigned PC_MAX        = 64;

    // pc is sized for the widest supported XLEN; narrower builds use the low bits.
    typedef struct packed {
        logic [PC_MAX-1:0] pc;
        logic [31:0]       inst;
        logic              filled;
    } fetch_entry_t;

    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// In-order circular buffer: entries are allocated at the tail when a fetch is
// granted, filled in grant order as responses return, and popped at the head.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF,
    localparam int unsigned CW   = cnt_width(DEPTH),
    localparam int unsigned PW   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alloc_i,
    input  logic [XLEN-1:0] alloc_pc_i,
    input  logic            fill_i,
    input  logic [31:0]     fill_data_i,
    input  logic            pop_i,
    input  logic            flush_i,
    output logic [CW-1:0]   count_o,
    output logic            head_valid_o,
    output logic [31:0]     head_inst_o,
    output logic [XLEN-1:0] head_pc_o
);

    fetch_entry_t  ent_q [DEPTH];
    logic [PW-1:0] head_q, tail_q, fill_q;
    logic [CW-1:0] count_q, count_d;
    logic          pop;

    assign head_valid_o = ent_q[head_q].filled;
    assign pop          = pop_i && head_valid_o;
    assign count_o      = count_q;
    assign head_inst_o  = head_valid_o ? ent_q[head_q].inst : 32'h0;
    assign head_pc_o    = head_valid_o ? ent_q[head_q].pc[XLEN-1:0] : '0;

    always_comb begin
        count_d = count_q + CW'(alloc_i) - CW'(pop);
    end

    // Tail, fill and head slots are always distinct when used together, so the
    // three writes below never collide.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            fill_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) ent_q[i] <= '0;
        end else if (flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            fill_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) ent_q[i].filled <= 1'b0;
        end else begin
            if (alloc_i) begin
                ent_q[tail_q].pc     <= PC_MAX'(alloc_pc_i);
                ent_q[tail_q].inst   <= 32'h0;
                ent_q[tail_q].filled <= 1'b0;
                tail_q               <= tail_q + 1'b1;
            end
            if (fill_i) begin
                ent_q[fill_q].inst   <= fill_data_i;
                ent_q[fill_q].filled <= 1'b1;
                fill_q               <= fill_q + 1'b1;
            end
            if (pop) begin
                ent_q[head_q].filled <= 1'b0;
                head_q               <= head_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Pipelined instruction fetcher: fetch PC, request credits, stale-response
// discard and decoder handshake. FETCH_PERF_EN adds the stall_cycles counter.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN      = XLEN_DEF,
    parameter int unsigned     DEPTH     = DEPTH_DEF,
    parameter logic [XLEN-1:0] RESET_VEC = RESET_VEC_DEF[XLEN-1:0],
    localparam int unsigned    CW        = cnt_width(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_addr,
    output logic            inst_valid,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            inst_ready
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     stall_cycles
`endif
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   outst_q, outst_d;
    logic [CW-1:0]   disc_q, disc_d;
    logic [CW:0]     disc_sum;
    logic [CW-1:0]   alloc_cnt;
    logic            grant, rsp_any, drop, fill, pop;

    assign imem_req  = rst && !redirect_valid && (alloc_cnt < CW'(DEPTH));
    assign imem_addr = pc_q;
    assign grant     = imem_req && imem_gnt;
    assign rsp_any   = imem_rvalid && ((disc_q != '0) || (outst_q != '0));
    assign drop      = imem_rvalid && (disc_q != '0);
    assign fill      = imem_rvalid && (disc_q == '0) && (outst_q != '0);
    assign pop       = inst_valid && inst_ready;

    always_comb begin
        pc_d     = pc_q;
        outst_d  = outst_q;
        disc_d   = disc_q;
        disc_sum = {1'b0, disc_q} + {1'b0, outst_q} + (CW+1)'(grant) - (CW+1)'(rsp_any);
        if (drop) disc_d = disc_q - 1'b1;
        if (redirect_valid) begin
            pc_d    = {redirect_addr[XLEN-1:2], 2'b00};
            outst_d = '0;
            // Total responses still owed by memory never exceed DEPTH in legal use.
            disc_d  = (disc_sum > (CW+1)'(DEPTH)) ? CW'(DEPTH) : disc_sum[CW-1:0];
        end else begin
            if (grant) pc_d = pc_q + XLEN'(4);
            outst_d = outst_q + CW'(grant) - CW'(fill);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q    <= RESET_VEC;
            outst_q <= '0;
            disc_q  <= '0;
        end else begin
            pc_q    <= pc_d;
            outst_q <= outst_d;
            disc_q  <= disc_d;
        end
    end

    fetch_queue #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk          (clk),
        .rst          (rst),
        .alloc_i      (grant),
        .alloc_pc_i   (pc_q),
        .fill_i       (fill),
        .fill_data_i  (imem_rdata),
        .pop_i        (pop),
        .flush_i      (redirect_valid),
        .count_o      (alloc_cnt),
        .head_valid_o (inst_valid),
        .head_inst_o  (inst),
        .head_pc_o    (inst_pc)
    );

`ifdef FETCH_PERF_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= 32'h0;
        end else if (inst_ready && !inst_valid && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'h1;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory model, scoreboard, vector tables.
module tb_fetch_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_addr = 32'h0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;
`ifdef FETCH_PERF_EN
    logic [31:0] stall_cycles;
    int          stall_m = 0;
`endif

    fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_VEC(32'h0)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready)
`ifdef FETCH_PERF_EN
        ,
        .stall_cycles   (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [63:0] exp_q[$];
    logic [31:0] mem_q[$];
    int          mem_ep[$];
    int          epoch = 0;
    int          n_filled = 0;
    logic [31:0] model_pc = 32'h0;
    int          n_grants = 0;
    int          n_pops = 0;
    logic [31:0] last_pop_pc = 32'h0;

    logic        s_req, s_valid;
    logic [31:0] s_addr, s_pc;

    typedef struct {
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
    } su_vec_t;

    typedef struct {
        logic [31:0] raddr;
        logic [31:0] exp_addr;
    } rd_vec_t;

    su_vec_t su_tbl[6];
    rd_vec_t rd_tbl[4];

    function automatic logic [31:0] mk_inst(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_1357;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs at negedge, sample settled outputs, update models.
    task automatic step(input bit gnt, input bit rv_en, input bit rdy,
                        input bit redir, input logic [31:0] raddr);
        logic [31:0] a;
        logic [63:0] e;
        bit          cur;
        @(negedge clk);
        imem_gnt       = gnt;
        inst_ready     = rdy;
        redirect_valid = redir;
        redirect_addr  = raddr;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        cur            = 1'b0;
        if (rv_en && mem_q.size() > 0) begin
            a           = mem_q.pop_front();
            cur         = (mem_ep.pop_front() == epoch);
            imem_rvalid = 1'b1;
            imem_rdata  = mk_inst(a);
        end
        #1;
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_valid = inst_valid;
        s_pc    = inst_pc;
        chk("req", 64'(imem_req), 64'(!redir && exp_q.size() < DEPTH));
        if (imem_req) chk("addr", 64'(imem_addr), 64'(model_pc));
        chk("inst_valid", 64'(inst_valid), 64'(n_filled > 0));
`ifdef FETCH_PERF_EN
        chk("stall", 64'(stall_cycles), 64'(stall_m));
        if (rdy && !inst_valid) stall_m++;
`endif
        if (inst_valid && rdy) begin
            if (exp_q.size() == 0) begin
                chk("pop_unexpected", {inst_pc, inst}, 64'h0);
            end else begin
                e = exp_q.pop_front();
                chk("pop_data", {inst_pc, inst}, e);
            end
            if (n_filled > 0) n_filled--;
            n_pops++;
            last_pop_pc = inst_pc;
        end
        if (cur) n_filled++;
        if (redir) begin
            exp_q.delete();
            n_filled = 0;
            epoch++;
            model_pc = {raddr[31:2], 2'b00};
        end else if (imem_req && gnt) begin
            exp_q.push_back({model_pc, mk_inst(model_pc)});
            mem_q.push_back(imem_addr);
            mem_ep.push_back(epoch);
            model_pc = model_pc + 32'd4;
            n_grants++;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 14; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"}, 64'(imem_req), 64'h0);
        chk({tag, "_addr"}, 64'(imem_addr), 64'h0);
        chk({tag, "_valid"}, 64'(inst_valid), 64'h0);
        chk({tag, "_inst"}, 64'(inst), 64'h0);
        chk({tag, "_pc"}, 64'(inst_pc), 64'h0);
`ifdef FETCH_PERF_EN
        chk({tag, "_stall"}, 64'(stall_cycles), 64'h0);
`endif
    endtask

    initial begin
        int g0, p0;
        bit got;

        su_tbl[0] = '{32'h00, 1'b0, 32'h0};
        su_tbl[1] = '{32'h04, 1'b0, 32'h0};
        su_tbl[2] = '{32'h08, 1'b1, 32'h0};
        su_tbl[3] = '{32'h0C, 1'b1, 32'h4};
        su_tbl[4] = '{32'h10, 1'b1, 32'h8};
        su_tbl[5] = '{32'h14, 1'b1, 32'hC};
        rd_tbl[0] = '{32'h0000_0103, 32'h0000_0100};
        rd_tbl[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC};
        rd_tbl[2] = '{32'h0000_0002, 32'h0000_0000};
        rd_tbl[3] = '{32'h1234_5677, 32'h1234_5674};

        // Reset state
        #12;
        check_reset_outputs("rst");
        @(negedge clk);
        rst = 1'b1;

        // Zero-wait memory startup, compared against the hand-derived table
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
            chk("su_req", 64'(s_req), 64'h1);
            chk("su_addr", 64'(s_addr), 64'(su_tbl[i].addr));
            chk("su_valid", 64'(s_valid), 64'(su_tbl[i].valid));
            if (su_tbl[i].valid) chk("su_pc", 64'(s_pc), 64'(su_tbl[i].pc));
        end

        // Backpressure: two entries are allocated here, so two more grants fill DEPTH
        g0 = n_grants;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("bp_grants", 64'(n_grants - g0), 64'(DEPTH - 2));
        chk("bp_req_low", 64'(s_req), 64'h0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        g0 = n_grants;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("bp_one_more", 64'(n_grants - g0), 64'h1);
        drain();

        // Redirect with three requests in flight
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0103);
        p0 = n_pops;
        got = 1'b0;
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("redir_addr", 64'(s_addr), 64'h100);
        for (int i = 0; i < 15 && !got; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
            if (n_pops != p0) got = 1'b1;
        end
        chk("redir_first_pc", got ? 64'(last_pop_pc) : 64'hDEAD_BEEF, 64'h100);
        drain();

        // Redirect latency with single-cycle memory and nothing in flight
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0200);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("lat_n1_req", 64'(s_req), 64'h1);
        chk("lat_n1_addr", 64'(s_addr), 64'h200);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("lat_n2_valid", 64'(s_valid), 64'h0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("lat_n3_valid", 64'(s_valid), 64'h1);
        chk("lat_n3_pc", 64'(s_pc), 64'h200);
        drain();

        // Redirect address alignment
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1, rd_tbl[i].raddr);
            step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
            chk("redir_align", 64'(s_addr), 64'(rd_tbl[i].exp_addr));
        end

        // Address wrap at the top of the 32-bit space
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("wrap_addr", 64'(s_addr), 64'h0);
        drain();

        // Redirect in the same cycle as a response, with grants streaming
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0400);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        drain();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            bit rd;
            rd = ($urandom_range(0, 15) == 0) && (mem_q.size() <= DEPTH);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) != 0, rd, $urandom & 32'h0000_FFFF);
        end
        drain();

        // Asynchronous reset in the middle of traffic
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        imem_gnt = 1'b0; imem_rvalid = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0;
        exp_q.delete();
        mem_q.delete();
        mem_ep.delete();
        epoch++;
        n_filled = 0;
        model_pc = 32'h0;
`ifdef FETCH_PERF_EN
        stall_m = 0;
`endif
        @(negedge clk);
        rst = 1'b1;
`ifdef FETCH_PERF_EN
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        inst_ready = 1'b0;
        #1;
        chk("stall_5", 64'(stall_cycles), 64'h5);
        stall_m = 5;
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        redirect_valid = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
`endif
        p0 = n_pops;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
            if (n_pops != p0) got = 1'b1;
        end
        chk("post_rst_first_pc", got ? 64'(last_pop_pc) : 64'hDEAD_BEEF, 64'h0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
